// File: rtl/comparator_serial_nbit_pkg.sv
// Shared definitions for the bit-serial magnitude comparator: FSM state
// encodings, one-hot result bit positions and the bit-counter sizing helper.
package comparator_serial_nbit_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COMPARE = 2'b01,
        DONE    = 2'b10
    } state_t;

    // Bit positions of the one-hot result vector {GT, EQ, LT}
    localparam int RES_LT = 0;
    localparam int RES_EQ = 1;
    localparam int RES_GT = 2;

    // Ceiling log2 with a floor of 1 so the counter is never zero-width
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/comparator_serial_nbit_cell.sv
// Combinational gate-level 1-bit magnitude compare cell.
module comparator_cell_1bit (
    input  logic A,
    input  logic B,
    output logic GT,
    output logic EQ,
    output logic LT
);

    assign GT = A & ~B;
    assign LT = ~A & B;
    assign EQ = ~(A ^ B);

endmodule

// File: rtl/comparator_serial_nbit.sv
// Bit-serial N-bit magnitude comparator. Operands are captured on start and
// shifted MSB-first through a single 1-bit compare cell; the one-hot
// GT/EQ/LT result is registered and held until the next accepted start.
module comparator_serial_nbit
    import comparator_serial_nbit_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             GT,
    output logic             EQ,
    output logic             LT
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic [CNT_W-1:0] cnt;
    logic             diff_seen;
    logic [2:0]       sticky_res;
    logic [2:0]       result;

    logic             bit_gt;
    logic             bit_eq;
    logic             bit_lt;
    logic [2:0]       cell_res;
    logic [2:0]       final_res;

    comparator_cell_1bit u_cell (
        .A  (shift_a[WIDTH-1]),
        .B  (shift_b[WIDTH-1]),
        .GT (bit_gt),
        .EQ (bit_eq),
        .LT (bit_lt)
    );

    // Pack the cell outputs into the one-hot result layout and pick the
    // result to commit on the last bit: an earlier difference wins over
    // whatever the final bit says.
    always_comb begin
        cell_res         = '0;
        cell_res[RES_GT] = bit_gt;
        cell_res[RES_EQ] = bit_eq;
        cell_res[RES_LT] = bit_lt;
        final_res        = diff_seen ? sticky_res : cell_res;
    end

    assign GT = result[RES_GT];
    assign EQ = result[RES_EQ];
    assign LT = result[RES_LT];

    // Control FSM with shift registers, down-counter, sticky flag and result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            shift_a    <= '0;
            shift_b    <= '0;
            cnt        <= '0;
            diff_seen  <= 1'b0;
            sticky_res <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        shift_a    <= A;
                        shift_b    <= B;
                        cnt        <= CNT_W'(WIDTH - 1);
                        result     <= '0;
                        diff_seen  <= 1'b0;
                        sticky_res <= '0;
                        busy       <= 1'b1;
                        state      <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (EARLY_EXIT && !bit_eq) begin
                        result <= cell_res;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (cnt == '0) begin
                        result <= final_res;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        shift_a <= {shift_a[WIDTH-2:0], 1'b0};
                        shift_b <= {shift_b[WIDTH-2:0], 1'b0};
                        cnt     <= cnt - 1'b1;
                        if (!diff_seen && !bit_eq) begin
                            diff_seen  <= 1'b1;
                            sticky_res <= cell_res;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
